// File: rtl/mips_dump_streamer_pkg.sv
// Shared types and constants for the MIPS dump streamer.
// Holds FSM state encoding, default frame header bytes and sizing helpers.
// No logic; imported by the streamer and its byte selector.
package mips_dump_streamer_pkg;

  // 2-bit FSM encoding used by the streamer
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Default frame header bytes: 'R' for a register dump, 'M' for memory
  localparam logic [7:0] REG_HEADER_DEF = 8'h52;
  localparam logic [7:0] MEM_HEADER_DEF = 8'h4D;

  // Number of payload bytes in one dump (header excluded)
  function automatic int dump_bytes(input int word_count, input int word_size,
                                    input int bus_size);
    return word_count * (word_size / bus_size);
  endfunction

  // Width of a counter indexing n items, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_dump_streamer_if.sv
// Debugger/UART-facing signal bundle of the dump streamer.
// Carries start/abort requests, the two snapshot sources and the TX FIFO strobe.
// slave = the streamer itself; master = the debugger/UART side driving it.
interface mips_dump_streamer_if #(
  parameter int UART_BUS_SIZE = 8,
  parameter int WORD_SIZE     = 32,
  parameter int WORD_COUNT    = 32
);

  logic                              i_start_regs;
  logic                              i_start_mem;
  logic                              i_abort;
  logic                              i_uart_full;
  logic [WORD_COUNT*WORD_SIZE-1:0]   i_registers;
  logic [WORD_COUNT*WORD_SIZE-1:0]   i_memory;
  logic                              o_uart_wr;
  logic [UART_BUS_SIZE-1:0]          o_uart_data;
  logic                              o_busy;
  logic                              o_done;

  modport slave (
    input  i_start_regs, i_start_mem, i_abort, i_uart_full, i_registers, i_memory,
    output o_uart_wr, o_uart_data, o_busy, o_done
  );

  modport master (
    output i_start_regs, i_start_mem, i_abort, i_uart_full, i_registers, i_memory,
    input  o_uart_wr, o_uart_data, o_busy, o_done
  );

endinterface

// File: rtl/mips_dump_streamer_dump_byte_mux.sv
// Selects byte idx_i of a packed word array: slot 0 first, MSB first within a slot.
// Purely combinational, zero latency.
// No flow control; the caller holds idx_i stable while it needs the byte.
module dump_byte_mux #(
  parameter int UART_BUS_SIZE = 8,
  parameter int WORD_SIZE     = 32,
  parameter int WORD_COUNT    = 32,
  parameter int IDX_W         = 7
) (
  input  logic [WORD_COUNT*WORD_SIZE-1:0] snap_i,
  input  logic [IDX_W-1:0]                idx_i,
  output logic [UART_BUS_SIZE-1:0]        byte_o
);

  localparam int BPW    = WORD_SIZE / UART_BUS_SIZE;
  localparam int NBYTES = WORD_COUNT * BPW;

  // Bytes re-laid out in transmit order so the runtime select is a plain index
  logic [UART_BUS_SIZE-1:0] bytes [NBYTES];

  for (genvar g = 0; g < NBYTES; g++) begin : g_byte
    assign bytes[g] =
      snap_i[(g / BPW) * WORD_SIZE + (BPW - 1 - (g % BPW)) * UART_BUS_SIZE +: UART_BUS_SIZE];
  end

  // Index into the reordered byte table; out-of-range indices read as zero
  always_comb begin
    byte_o = '0;
    if (int'(idx_i) < NBYTES) byte_o = bytes[idx_i];
  end

endmodule

// File: rtl/mips_dump_streamer.sv
// Snapshots the register bank or data memory and streams it as header + bytes to the UART TX FIFO.
// Header goes out the cycle after the start is accepted; then one byte per clock when not stalled.
// Stalls (holds byte and index, no write) while i_uart_full; i_abort drops the frame at once.
module mips_dump_streamer
  import mips_dump_streamer_pkg::*;
#(
  parameter int                       UART_BUS_SIZE = 8,
  parameter int                       WORD_SIZE     = 32,
  parameter int                       WORD_COUNT    = 32,
  parameter logic [UART_BUS_SIZE-1:0] REG_HEADER    = UART_BUS_SIZE'(REG_HEADER_DEF),
  parameter logic [UART_BUS_SIZE-1:0] MEM_HEADER    = UART_BUS_SIZE'(MEM_HEADER_DEF)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mips_dump_streamer_if.slave  bus
);

  localparam int SNAP_W = WORD_COUNT * WORD_SIZE;
  localparam int NBYTES = dump_bytes(WORD_COUNT, WORD_SIZE, UART_BUS_SIZE);
  localparam int CNT_W  = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  state_e                   state_q, state_d;
  logic [SNAP_W-1:0]        snap_q, snap_d;
  logic [UART_BUS_SIZE-1:0] hdr_q, hdr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     uart_wr;
  logic [UART_BUS_SIZE-1:0] uart_data;
  logic                     busy;
  logic                     done;
  logic [UART_BUS_SIZE-1:0] mux_byte;

  dump_byte_mux #(
    .UART_BUS_SIZE (UART_BUS_SIZE),
    .WORD_SIZE     (WORD_SIZE),
    .WORD_COUNT    (WORD_COUNT),
    .IDX_W         (CNT_W)
  ) u_byte_mux (
    .snap_i (snap_q),
    .idx_i  (cnt_q),
    .byte_o (mux_byte)
  );

  // State, snapshot, header and byte index registers; reset abandons any frame
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      hdr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; writes are combinational on !full so the FIFO sees one per clock
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    uart_wr   = 1'b0;
    uart_data = '0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Registers win when both starts arrive together
        if (bus.i_start_regs) begin
          snap_d  = bus.i_registers;
          hdr_d   = REG_HEADER;
          state_d = ST_HEADER;
        end else if (bus.i_start_mem) begin
          snap_d  = bus.i_memory;
          hdr_d   = MEM_HEADER;
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        busy      = 1'b1;
        uart_data = hdr_q;
        if (bus.i_abort) begin
          state_d = ST_IDLE;
        end else if (!bus.i_uart_full) begin
          uart_wr = 1'b1;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        busy      = 1'b1;
        uart_data = mux_byte;
        if (bus.i_abort) begin
          state_d = ST_IDLE;
        end else if (!bus.i_uart_full) begin
          uart_wr = 1'b1;
          // Index stops at the last byte so it never wraps inside a frame
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_uart_wr   = uart_wr;
  assign bus.o_uart_data = uart_data;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;

endmodule

// File: tb/tb_mips_dump_streamer.sv
// Directed bench for mips_dump_streamer: a queue-based frame model checked on every falling edge.
// Stimulus changes 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mips_dump_streamer;

  localparam int WC    = 32;
  localparam int WS    = 32;
  localparam int FRAME = 1 + WC * WS / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_dump_streamer_if bus ();

  mips_dump_streamer dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         wr_count    = 0;
  int         done_count  = 0;
  int         busy_cycles = 0;
  bit         expect_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected frame: header, then slot 0..WC-1, each word most-significant byte first
  task automatic arm_frame(input logic [7:0] hdr, input logic [WC*WS-1:0] bank);
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(hdr);
    for (int k = 0; k < WC; k++) begin
      w = bank[k*WS +: WS];
      for (int j = 3; j >= 0; j--) exp_q.push_back(8'(w >> (8 * j)));
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin : cmp
    logic [7:0] e;
    if (expect_done) begin
      chk("done_after_last", 32'(bus.o_done), 32'd1);
      expect_done = 1'b0;
    end else if (bus.o_done) begin
      chk("spurious_done", 32'(bus.o_done), 32'd0);
    end
    if (bus.o_done) done_count++;
    if (bus.o_busy) busy_cycles++;
    if (bus.o_uart_wr) begin
      wr_count++;
      got_q.push_back(bus.o_uart_data);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.o_uart_wr), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("byte%0d", wr_count - 1), 32'(bus.o_uart_data), 32'(e));
        if (exp_q.size() == 0) expect_done = 1'b1;
      end
    end
    if (!bus.o_busy) begin
      chk("idle_wr", 32'(bus.o_uart_wr), 32'd0);
      chk("idle_data", 32'(bus.o_uart_data), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit regs, input bit mem);
    wr_count    = 0;
    done_count  = 0;
    busy_cycles = 0;
    got_q.delete();
    bus.i_start_regs = regs;
    bus.i_start_mem  = mem;
    if (regs)     arm_frame(8'h52, bus.i_registers);
    else if (mem) arm_frame(8'h4D, bus.i_memory);
    tick();
    bus.i_start_regs = 1'b0;
    bus.i_start_mem  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit scramble, input string name);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      tick();
      n++;
      if (scramble)
        for (int k = 0; k < WC; k++) bus.i_registers[k*WS +: WS] = $urandom;
    end
    if (done_count == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int c = 0;
    while (wr_count < n && c < budget) begin
      tick();
      c++;
    end
    if (wr_count < n) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d writes, expected %0d", name, wr_count, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start_regs = 1'b0;
    bus.i_start_mem  = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_uart_full  = 1'b0;
    for (int k = 0; k < WC; k++) begin
      bus.i_registers[k*WS +: WS] = 32'hA0B0C000 + 32'(k);
      bus.i_memory[k*WS +: WS]    = 32'h11223344 + 32'(k) * 32'h01010101;
    end

    // Reset state
    #1;
    chk("rst_wr", 32'(bus.o_uart_wr), 32'd0);
    chk("rst_data", 32'(bus.o_uart_data), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // 1: register dump, no back-pressure
    start(1'b1, 1'b0);
    wait_done(300, 1'b0, "t1");
    chk("t1_writes", 32'(wr_count), 32'(FRAME));
    chk("t1_dones", 32'(done_count), 32'd1);
    chk("t1_busy_cycles", 32'(busy_cycles), 32'd129);
    if (got_q.size() == FRAME) begin
      chk("t1_hdr", 32'(got_q[0]), 32'h52);
      chk("t1_b1", 32'(got_q[1]), 32'hA0);
      chk("t1_b2", 32'(got_q[2]), 32'hB0);
      chk("t1_b3", 32'(got_q[3]), 32'hC0);
      chk("t1_b4", 32'(got_q[4]), 32'h00);
      chk("t1_b8", 32'(got_q[8]), 32'h01);
      chk("t1_last", 32'(got_q[128]), 32'h1F);
    end
    tick();

    // 2: memory dump with 5 full cycles right after the header
    start(1'b0, 1'b1);
    tick();
    bus.i_uart_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_stall_wr", 32'(bus.o_uart_wr), 32'd0);
      chk("t2_stall_data", 32'(bus.o_uart_data), 32'h11);
      tick();
    end
    bus.i_uart_full = 1'b0;
    wait_done(300, 1'b0, "t2");
    chk("t2_writes", 32'(wr_count), 32'(FRAME));
    chk("t2_busy_cycles", 32'(busy_cycles), 32'd134);
    if (got_q.size() == FRAME) begin
      chk("t2_hdr", 32'(got_q[0]), 32'h4D);
      chk("t2_b1", 32'(got_q[1]), 32'h11);
      chk("t2_b2", 32'(got_q[2]), 32'h22);
      chk("t2_b3", 32'(got_q[3]), 32'h33);
      chk("t2_b4", 32'(got_q[4]), 32'h44);
    end
    tick();

    // 3: both starts together, then a stray memory start mid-frame
    start(1'b1, 1'b1);
    repeat (20) tick();
    bus.i_start_mem = 1'b1;
    tick();
    bus.i_start_mem = 1'b0;
    wait_done(300, 1'b0, "t3");
    chk("t3_writes", 32'(wr_count), 32'(FRAME));
    chk("t3_dones", 32'(done_count), 32'd1);
    if (got_q.size() > 0) chk("t3_hdr", 32'(got_q[0]), 32'h52);
    tick();

    // 4: register bus scrambled every cycle after the start
    for (int k = 0; k < WC; k++) bus.i_registers[k*WS +: WS] = 32'h5EED0000 + 32'(k) * 3;
    start(1'b1, 1'b0);
    wait_done(300, 1'b1, "t4");
    chk("t4_writes", 32'(wr_count), 32'(FRAME));
    if (got_q.size() == FRAME) begin
      chk("t4_b1", 32'(got_q[1]), 32'h5E);
      chk("t4_b2", 32'(got_q[2]), 32'hED);
      chk("t4_last", 32'(got_q[128]), 32'h5D);
    end
    tick();

    // 5: abort after header + 10 data bytes, then a fresh memory dump
    start(1'b1, 1'b0);
    wait_writes(11, 200, "t5");
    bus.i_abort = 1'b1;
    #1;
    chk("t5_abort_wr", 32'(bus.o_uart_wr), 32'd0);
    tick();
    bus.i_abort = 1'b0;
    chk("t5_busy_after", 32'(bus.o_busy), 32'd0);
    repeat (3) tick();
    chk("t5_writes", 32'(wr_count), 32'd11);
    chk("t5_dones", 32'(done_count), 32'd0);
    exp_q.delete();
    start(1'b0, 1'b1);
    wait_done(300, 1'b0, "t5b");
    chk("t5b_writes", 32'(wr_count), 32'(FRAME));
    chk("t5b_dones", 32'(done_count), 32'd1);
    if (got_q.size() > 0) chk("t5b_hdr", 32'(got_q[0]), 32'h4D);
    tick();

    // 6: asynchronous reset between edges at byte 50
    start(1'b1, 1'b0);
    wait_writes(50, 200, "t6");
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_wr", 32'(bus.o_uart_wr), 32'd0);
    chk("t6_rst_data", 32'(bus.o_uart_data), 32'd0);
    chk("t6_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("t6_rst_done", 32'(bus.o_done), 32'd0);
    exp_q.delete();
    tick();
    tick();
    #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_writes", 32'(wr_count), 32'd50);
    chk("t6_dones", 32'(done_count), 32'd0);
    chk("t6_idle_busy", 32'(bus.o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
